matrix_scanner: RTL and testbench

MATRIX_SCANNER -- requirements
Module: matrix_scanner

---
 rtl/matrix_scanner_if.sv | 24 ++
 rtl/matrix_scanner.sv | 81 ++++++++
 tb/tb_matrix_scanner.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/matrix_scanner_if.sv
// rtl/matrix_scanner_if.sv - framebuffer write/readback and LED matrix drive signals for matrix_scanner
interface matrix_scanner_if;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [3:0]  wr_col;
  logic        wr_val;
  logic        clr;
  logic [2:0]  rd_row;
  logic [3:0]  rd_col;
  logic        rd_pixel;
  logic [7:0]  MATRIX_ROW;
  logic [15:0] MATRIX_COL;
  logic        frame_done;

  modport master (
    output wr_en, wr_row, wr_col, wr_val, clr, rd_row, rd_col,
    input  rd_pixel, MATRIX_ROW, MATRIX_COL, frame_done
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_val, clr, rd_row, rd_col,
    output rd_pixel, MATRIX_ROW, MATRIX_COL, frame_done
  );
endinterface

// File: rtl/matrix_scanner.sv
// rtl/matrix_scanner.sv - 8x16 framebuffer with row-multiplexed LED matrix scan
// MATRIX_SCANNER_BLANK_EN inserts one dark BLANK cycle before each row is shown.
module matrix_scanner #(
  parameter int ROW_DIV = 1024
) (
  input  logic           i_clk,
  input  logic           i_reset,
  matrix_scanner_if.slave bus
);

  localparam logic [0:0]  ST_BLANK = 1'b0;
  localparam logic [0:0]  ST_SHOW  = 1'b1;
  localparam logic [15:0] DIV_LAST = 16'(ROW_DIV - 1);
`ifdef MATRIX_SCANNER_BLANK_EN
  localparam logic [0:0]  ST_RESET = ST_BLANK;
`else
  localparam logic [0:0]  ST_RESET = ST_SHOW;
`endif

  logic [15:0] r_fb [8];
  logic        r_rd_pixel;
  logic [2:0]  r_row;
  logic [15:0] r_div;
  logic [0:0]  r_state;
  logic [15:0] r_mcol;

  logic        w_show;
  logic        w_last;
  logic [2:0]  w_row_next;

  assign w_show     = (r_state == ST_SHOW);
  assign w_last     = w_show && (r_div == DIV_LAST);
  assign w_row_next = r_row + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) r_fb[i] <= 16'd0;
      r_rd_pixel <= 1'b0;
      r_row      <= 3'd0;
      r_div      <= 16'd0;
      r_state    <= ST_RESET;
      r_mcol     <= 16'd0;
    end else begin
      // Readback samples the pre-write contents, so a same-cycle write is not visible.
      r_rd_pixel <= r_fb[bus.rd_row][bus.rd_col];
      if (bus.clr) begin
        for (int i = 0; i < 8; i++) r_fb[i] <= 16'd0;
      end else if (bus.wr_en) begin
        r_fb[bus.wr_row][bus.wr_col] <= bus.wr_val;
      end

      case (r_state)
        ST_BLANK: begin
          r_state <= ST_SHOW;
          r_div   <= 16'd0;
          r_mcol  <= r_fb[r_row];
        end
        default: begin
          if (w_last) begin
            r_row <= w_row_next;
            r_div <= 16'd0;
`ifdef MATRIX_SCANNER_BLANK_EN
            r_state <= ST_BLANK;
`else
            r_mcol  <= r_fb[w_row_next];
`endif
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
      endcase
    end
  end

  // Drive outputs are forced dark while reset is held, even before the reset edge lands.
  assign bus.MATRIX_ROW = (w_show && !i_reset) ? (8'd1 << r_row) : 8'd0;
  assign bus.MATRIX_COL = (w_show && !i_reset) ? r_mcol : 16'd0;
  assign bus.frame_done = w_last && (r_row == 3'd7) && !i_reset;
  assign bus.rd_pixel   = r_rd_pixel;

endmodule

// File: tb/tb_matrix_scanner.sv
// tb/tb_matrix_scanner.sv - randomized and directed checks of matrix_scanner against a timing model
module tb_matrix_scanner;
  localparam int RD = 4;
`ifdef MATRIX_SCANNER_BLANK_EN
  localparam int P   = RD + 1;
  localparam bit BLK = 1'b1;
`else
  localparam int P   = RD;
  localparam bit BLK = 1'b0;
`endif
  localparam int FRAME = 8 * P;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_scanner_if bus();

  matrix_scanner #(.ROW_DIV(RD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int t = 0;
  int cyc = 0;
  int last_fd = -1;
  logic [15:0] m_fb [8];
  logic [15:0] m_snap;
  logic        m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int row_of(input int tt);
    return (tt / P) % 8;
  endfunction

  function automatic bit show_of(input int tt);
    return BLK ? ((tt % P) != 0) : 1'b1;
  endfunction

  function automatic bit entry_of(input int tt);
    return BLK ? ((tt % P) == 1) : ((tt % P) == 0);
  endfunction

  task automatic check_outputs();
    logic [7:0]  e_row;
    logic [15:0] e_col;
    logic        e_fd;
    if (rst) begin
      e_row = 8'd0; e_col = 16'd0; e_fd = 1'b0;
    end else begin
      e_row = show_of(t) ? (8'd1 << row_of(t)) : 8'd0;
      e_col = show_of(t) ? m_snap : 16'd0;
      e_fd  = show_of(t) && (row_of(t) == 7) && ((t % P) == P - 1);
    end
    chk("matrix_row", 32'(bus.MATRIX_ROW), 32'(e_row));
    chk("matrix_col", 32'(bus.MATRIX_COL), 32'(e_col));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    chk("rd_pixel",   32'(bus.rd_pixel),   32'(m_rd));
    if (bus.frame_done === 1'b1 && !rst) begin
      if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(FRAME));
      last_fd = cyc;
    end
  endtask

  task automatic update_model();
    if (rst) begin
      t = 0;
      for (int i = 0; i < 8; i++) m_fb[i] = 16'd0;
      m_snap  = 16'd0;
      m_rd    = 1'b0;
      last_fd = -1;
    end else begin
      t++;
      m_rd = m_fb[bus.rd_row][bus.rd_col];
      if (entry_of(t)) m_snap = m_fb[row_of(t)];
      if (bus.clr) begin
        for (int i = 0; i < 8; i++) m_fb[i] = 16'd0;
      end else if (bus.wr_en) begin
        m_fb[bus.wr_row][bus.wr_col] = bus.wr_val;
      end
    end
    cyc++;
  endtask

  task automatic run(input bit r, input bit we, input int wrow, input int wcol, input bit wv,
                     input bit c, input int rrow, input int rcol);
    rst        = r;
    bus.wr_en  = we;
    bus.wr_row = 3'(wrow);
    bus.wr_col = 4'(wcol);
    bus.wr_val = wv;
    bus.clr    = c;
    bus.rd_row = 3'(rrow);
    bus.rd_col = 4'(rcol);
    #1 check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    run(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wait_row(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (bus.MATRIX_ROW !== target && n < 200) begin
      idle();
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 32'(bus.MATRIX_ROW), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_row = 3'd0; bus.wr_col = 4'd0; bus.wr_val = 1'b0;
    bus.clr = 1'b0; bus.rd_row = 3'd0; bus.rd_col = 4'd0;
    @(posedge clk);
    update_model();
    #1;
    run(1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 0, 0);
    run(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);

    // Release reset: dark BLANK cycle first only when blanking is built in.
    rst = 1'b0;
    #1 chk("release_row", 32'(bus.MATRIX_ROW), BLK ? 32'h00 : 32'h01);
    run(1'b0, 1'b1, 2, 5, 1'b1, 1'b0, 1, 1);
    wait_row(8'h04, "row2");
    chk("row2_col", 32'(bus.MATRIX_COL), 32'h0020);
    for (int i = 0; i < 2 * FRAME; i++) idle();

    run(1'b0, 1'b1, 3, 7, 1'b1, 1'b0, 3, 7);
    chk("same_cycle_rd", 32'(bus.rd_pixel), 32'h0);
    run(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 3, 7);
    chk("next_cycle_rd", 32'(bus.rd_pixel), 32'h1);

    run(1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
    run(1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 0, 0);
    run(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("clr_wins_rd", 32'(bus.rd_pixel), 32'h0);
    wait_row(8'h80, "row7");
    wait_row(8'h01, "row0");
    chk("clr_row0_col", 32'(bus.MATRIX_COL), 32'h0);

    wait_row(8'h20, "row5");
    idle();
    rst = 1'b1;
    #1 chk("rst_row", 32'(bus.MATRIX_ROW), 32'h0);
    chk("rst_col", 32'(bus.MATRIX_COL), 32'h0);
    run(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    run(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    #1 chk("rst_release_row", 32'(bus.MATRIX_ROW), BLK ? 32'h00 : 32'h01);
    idle();
    chk("rst_then_row0", 32'(bus.MATRIX_ROW), BLK ? 32'h01 : 32'h01);

    for (int i = 0; i < 600; i++) begin
      run(1'b0, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 3 * FRAME; i++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
